// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 8-bit combinational ALU: valid/ready command in,
// register-file operand fetch, ALU drive, result capture/writeback, response out.
module alu_cmd_sequencer #(
   parameter int REG_ADDR_W  = 2,
   parameter bit CLAMP_SHIFT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [3:0]            i_cmd_op,
   input  logic [REG_ADDR_W-1:0] i_cmd_rd,
   input  logic [REG_ADDR_W-1:0] i_cmd_rs1,
   input  logic [REG_ADDR_W-1:0] i_cmd_rs2,
   input  logic                  i_cmd_use_imm,
   input  logic [7:0]            i_cmd_imm,
   output logic [7:0]            o_alu_a,
   output logic [7:0]            o_alu_b,
   output logic [3:0]            o_alu_instr,
   input  logic [7:0]            i_alu_f,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [7:0]            o_rsp_data,
   output logic [REG_ADDR_W-1:0] o_rsp_rd,
   output logic                  o_rsp_zero,
   output logic                  o_rsp_err,
   output logic [1:0]            o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; valid may drop without penalty while ready is 0.
   localparam int         NREG    = 1 << REG_ADDR_W;
   localparam logic [3:0] OP_LOAD = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    r_cmd_ready;
   logic [3:0]              r_op;
   logic [REG_ADDR_W-1:0]   r_rd;
   logic [7:0]              r_imm;
   logic [7:0]              r_alu_a;
   logic [7:0]              r_alu_b;
   logic [3:0]              r_alu_instr;
   logic [7:0]              r_rsp_data;
   logic [REG_ADDR_W-1:0]   r_rsp_rd;
   logic                    r_rsp_zero;
   logic                    r_rsp_err;
   logic [7:0]              r_regs [NREG];

   logic                    w_accept;
   logic                    w_rsp_done;
   logic                    w_is_shift;
   logic                    w_op_load;
   logic                    w_op_illegal;
   logic [7:0]              w_b_sel;
   logic [7:0]              w_b_fwd;
   logic [7:0]              w_result;

   assign w_accept   = (r_state == S_IDLE) && r_cmd_ready && i_cmd_valid;
   assign w_rsp_done = (r_state == S_RESP) && i_rsp_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)   w_next_state = S_EXEC;
         S_EXEC:                  w_next_state = S_RESP;
         S_RESP:  if (w_rsp_done) w_next_state = S_IDLE;
         default:                 w_next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_cmd_ready = r_cmd_ready;
      o_rsp_valid = (r_state == S_RESP);
      o_dbg_state = r_state;
   end

   // Operand B selection; shift/rotate opcodes 0010-0101 see only B[2:0].
   assign w_b_sel    = i_cmd_use_imm ? i_cmd_imm : r_regs[i_cmd_rs2];
   assign w_is_shift = (i_cmd_op >= 4'h2) && (i_cmd_op <= 4'h5);
   assign w_b_fwd    = (CLAMP_SHIFT && w_is_shift) ? {5'b0, w_b_sel[2:0]} : w_b_sel;

   assign w_op_load    = (r_op == OP_LOAD);
   assign w_op_illegal = (r_op >= 4'hA) && (r_op <= 4'hE);

   always_comb begin
      w_result = i_alu_f;
      if (w_op_load) begin
         w_result = r_imm;
      end else if (w_op_illegal) begin
         w_result = 8'h00;
      end
   end

   // Ready is registered so it stays low for the cycle after a reset edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cmd_ready <= 1'b0;
      end else begin
         r_cmd_ready <= (w_next_state == S_IDLE);
      end
   end

   // Command capture and ALU drive.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op        <= 4'h0;
         r_rd        <= '0;
         r_imm       <= 8'h00;
         r_alu_a     <= 8'h00;
         r_alu_b     <= 8'h00;
         r_alu_instr <= 4'h0;
      end else if (w_accept) begin
         r_op        <= i_cmd_op;
         r_rd        <= i_cmd_rd;
         r_imm       <= i_cmd_imm;
         r_alu_a     <= r_regs[i_cmd_rs1];
         r_alu_b     <= w_b_fwd;
         r_alu_instr <= (i_cmd_op == OP_LOAD) ? 4'h0 : i_cmd_op;
      end
   end

   // Result capture; reset has priority so an abandoned EXEC never writes back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_data <= 8'h00;
         r_rsp_rd   <= '0;
         r_rsp_zero <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_rsp_data <= w_result;
         r_rsp_rd   <= r_rd;
         r_rsp_zero <= (w_result == 8'h00);
         r_rsp_err  <= w_op_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= 8'h00;
         end
      end else if ((r_state == S_EXEC) && !w_op_illegal) begin
         r_regs[r_rd] <= w_result;
      end
   end

   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_instr = r_alu_instr;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_rd    = r_rsp_rd;
   assign o_rsp_zero  = r_rsp_zero;
   assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_cmd_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [1:0] cmd_rd;
   logic [1:0] cmd_rs1;
   logic [1:0] cmd_rs2;
   logic       cmd_use_imm;
   logic [7:0] cmd_imm;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_instr;
   logic [7:0] alu_f;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [1:0] rsp_rd;
   logic       rsp_zero;
   logic       rsp_err;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_SHL  = 4'h2;
   localparam logic [3:0] OP_ROL  = 4'h4;
   localparam logic [3:0] OP_ROR  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_LOAD = 4'hF;

   alu_cmd_sequencer #(.REG_ADDR_W(2), .CLAMP_SHIFT(1'b1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_op      (cmd_op),
      .i_cmd_rd      (cmd_rd),
      .i_cmd_rs1     (cmd_rs1),
      .i_cmd_rs2     (cmd_rs2),
      .i_cmd_use_imm (cmd_use_imm),
      .i_cmd_imm     (cmd_imm),
      .o_alu_a       (alu_a),
      .o_alu_b       (alu_b),
      .o_alu_instr   (alu_instr),
      .i_alu_f       (alu_f),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_data    (rsp_data),
      .o_rsp_rd      (rsp_rd),
      .o_rsp_zero    (rsp_zero),
      .o_rsp_err     (rsp_err),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU: 0 ADD,1 SUB,2 SHL,3 SHR,4 ROL,5 ROR,6 AND,7 OR,8 XOR,9 NOT A.
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
      logic [15:0] d;
      d = {a, a};
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a << b;
         4'h3: return a >> b;
         4'h4: begin d = d << b[2:0]; return d[15:8]; end
         4'h5: begin d = d >> b[2:0]; return d[7:0];  end
         4'h6: return a & b;
         4'h7: return a | b;
         4'h8: return a ^ b;
         4'h9: return ~a;
         default: return 8'h00;
      endcase
   endfunction

   always_comb alu_f = alu_model(alu_a, alu_b, alu_instr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge where rsp_valid is expected high.
   task automatic send(input string tag, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic use_imm, input logic [7:0] imm);
      cmd_op      = op;
      cmd_rd      = rd;
      cmd_rs1     = rs1;
      cmd_rs2     = rs2;
      cmd_use_imm = use_imm;
      cmd_imm     = imm;
      cmd_valid   = 1'b1;
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "_exec_no_rsp"}, rsp_valid, 0);
      chk({tag, "_exec_ready_low"}, cmd_ready, 0);
      @(negedge clk);
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
   endtask

   task automatic take(input string tag, input logic [7:0] d, input logic [1:0] rd,
                       input logic z, input logic e);
      chk({tag, "_data"}, rsp_data, d);
      chk({tag, "_rd"},   rsp_rd,   rd);
      chk({tag, "_zero"}, rsp_zero, z);
      chk({tag, "_err"},  rsp_err,  e);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, rsp_valid, 0);
      chk({tag, "_ready_back"}, cmd_ready, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_alu_instr"}, alu_instr, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_rd"}, rsp_rd, 0);
      chk({tag, "_rsp_zero"}, rsp_zero, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 4'h0;
      cmd_rd      = 2'd0;
      cmd_rs1     = 2'd0;
      cmd_rs2     = 2'd0;
      cmd_use_imm = 1'b0;
      cmd_imm     = 8'h00;
      rsp_ready   = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready_after", cmd_ready, 1);

      // 1: loads and add
      send("load_r0", OP_LOAD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h3C);
      take("load_r0", 8'h3C, 2'd0, 1'b0, 1'b0);
      send("load_r1", OP_LOAD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
      take("load_r1", 8'h05, 2'd1, 1'b0, 1'b0);
      send("add_r2", OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'hFF);
      take("add_r2", 8'h41, 2'd2, 1'b0, 1'b0);

      // 2: subtract with borrow dropped, xor to zero
      send("sub_r3", OP_SUB, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00);
      take("sub_r3", 8'hC9, 2'd3, 1'b0, 1'b0);
      send("xor_zero", OP_XOR, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00);
      take("xor_zero", 8'h00, 2'd3, 1'b1, 1'b0);

      // 3: rotates and clamped shift
      send("ror1", OP_ROR, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01);
      take("ror1", 8'h1E, 2'd3, 1'b0, 1'b0);
      send("rol4", OP_ROL, 2'd3, 2'd0, 2'd0, 1'b1, 8'h04);
      take("rol4", 8'hC3, 2'd3, 1'b0, 1'b0);
      send("shl_clamp", OP_SHL, 2'd3, 2'd0, 2'd0, 1'b1, 8'h0A);
      chk("shl_clamp_alu_b", alu_b, 8'h02);
      take("shl_clamp", 8'hF0, 2'd3, 1'b0, 1'b0);

      // 4: illegal opcode leaves R1 alone
      send("illegal", 4'hB, 2'd1, 2'd0, 2'd0, 1'b1, 8'h77);
      take("illegal", 8'h00, 2'd1, 1'b1, 1'b1);
      send("read_r1", OP_OR, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00);
      take("read_r1", 8'h05, 2'd3, 1'b0, 1'b0);

      // 5: response back-pressure, commands ignored while busy
      send("hold", OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01);
      cmd_op      = OP_LOAD;
      cmd_rd      = 2'd3;
      cmd_use_imm = 1'b1;
      cmd_imm     = 8'h77;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, 8'h3D);
         chk("hold_ready_low", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("hold_release_valid", rsp_valid, 0);
      chk("hold_release_ready", cmd_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("next_accept_exec", rsp_valid, 0);
      @(negedge clk);
      chk("next_accept_valid", rsp_valid, 1);
      take("next_load", 8'h77, 2'd3, 1'b0, 1'b0);

      // 6: reset during EXEC abandons the add
      send("pre_reset", OP_LOAD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h55);
      take("pre_reset", 8'h55, 2'd2, 1'b0, 1'b0);
      cmd_op      = OP_ADD;
      cmd_rd      = 2'd2;
      cmd_rs1     = 2'd0;
      cmd_use_imm = 1'b1;
      cmd_imm     = 8'h10;
      cmd_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst_exec_state", dbg_state, 2'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst_exec");
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_exec_no_rsp", rsp_valid, 0);
      send("read_r2", OP_OR, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00);
      take("read_r2", 8'h00, 2'd3, 1'b1, 1'b0);
      send("read_r0", OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 8'h00);
      take("read_r0", 8'h00, 2'd3, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
